// File: rtl/fifo_uart_tx.sv
// Serial transmit drain for the synchronous FIFO: pops one word at a time and
// shifts it out on TXD as a start bit, DATA_BIT data bits (LSB first) and a stop bit.
module fifo_uart_tx #(
  parameter int DATA_BIT     = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                EMPTY,
  input  logic [DATA_BIT-1:0] DIN,
  output logic                REN,
  output logic                TXD,
  output logic                BUSY,
  output logic                DONE
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BIT) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_BIT-1:0] shreg_q, shreg_d;
  logic                ren_q, ren_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                baud_last;
  logic                fetch_ok;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    baud_last = (baud_q == BAUD_LAST);
    fetch_ok  = EN && !EMPTY;

    case (state_q)
      S_IDLE:  if (fetch_ok) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d = DIN;
        bit_d   = '0;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) state_d = S_STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = fetch_ok ? S_FETCH : S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state and registered, so the pins
    // change exactly on the edge that enters the corresponding state.
    ren_d  = (state_d == S_FETCH);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the shift register
  // is cleared on reset too, so a half-sent word cannot leak into the next frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ren_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ren_q   <= ren_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign REN  = ren_q;
  assign TXD  = txd_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with DATA_BIT=8, CLKS_PER_BIT=4 (40-cycle frames);
// a small FIFO model feeds DIN/EMPTY and counts pops.
module tb_fifo_uart_tx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] din   = 8'h00;
  logic       ren, txd, busy, done;

  int n_cmp = 0;
  int n_mis = 0;
  int pops = 0;
  int underflow = 0;
  logic [7:0] fifo_q[$];

  fifo_uart_tx #(.DATA_BIT(8), .CLKS_PER_BIT(4)) dut (
    .CLK   (clk),
    .RST   (rst_n),
    .EN    (en),
    .EMPTY (empty),
    .DIN   (din),
    .REN   (ren),
    .TXD   (txd),
    .BUSY  (busy),
    .DONE  (done)
  );

  always #5 clk = ~clk;

  // FIFO model: pop on a sampled REN, DOUT valid the following cycle, registered EMPTY.
  always @(posedge clk) begin
    if (ren) begin
      if (fifo_q.size() == 0) underflow++;
      else din <= fifo_q.pop_front();
      pops++;
    end
    empty <= (fifo_q.size() == 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for REN at successive negedges and checks how many cycles it took.
  task automatic wait_ren(input string name, input int exp_lat);
    int lat;
    bit found;
    found = 0;
    lat = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (ren === 1'b1) begin
        found = 1;
        lat = i;
      end
    end
    n_cmp++;
    if (!found || lat != exp_lat) begin
      n_mis++;
      $display("FAIL %s latency: got %0d (found=%0d) expected %0d", name, lat, found, exp_lat);
    end
  endtask

  // Called at the negedge where REN is high; walks FETCH, LOAD and the 40 frame cycles.
  task automatic check_frame(input logic [7:0] w, input string name, input int drop_en_at);
    logic       exp_txd;
    logic [3:0] got, exp;
    n_cmp++;
    if (ren !== 1'b1 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL %s fetch: ren=%b busy=%b expected ren=1 busy=1", name, ren, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (ren !== 1'b0 || txd !== 1'b1 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL %s load: ren=%b txd=%b busy=%b expected 0 1 1", name, ren, txd, busy);
    end
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (i * 4 + c == drop_en_at) en = 1'b0;
        if (i == 0)      exp_txd = 1'b0;
        else if (i == 9) exp_txd = 1'b1;
        else             exp_txd = w[i-1];
        got = {txd, done, ren, busy};
        exp = {exp_txd, (i == 9 && c == 3), 1'b0, 1'b1};
        n_cmp++;
        if (got !== exp) begin
          n_mis++;
          $display("FAIL %s bit%0d cyc%0d: txd/done/ren/busy got %b expected %b", name, i, c, got, exp);
        end
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    n_cmp++;
    if ({txd, done, ren, busy} !== 4'b1000) begin
      n_mis++;
      $display("FAIL %s idle: txd/done/ren/busy got %b expected 1000", name, {txd, done, ren, busy});
    end
  endtask

  task automatic check_pops(input string name, input int exp);
    n_cmp++;
    if (pops != exp) begin
      n_mis++;
      $display("FAIL %s pops: got %0d expected %0d", name, pops, exp);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    en = 1'b1;
    fifo_q.push_back(8'h81);
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if ({txd, done, ren, busy} !== 4'b1000) bad++;
    end
    n_cmp++;
    if (bad != 0 || empty !== 1'b0) begin
      n_mis++;
      $display("FAIL reset outputs: bad cycles %0d empty=%b expected 0 and 0", bad, empty);
    end
    check_pops("reset", 0);
    rst_n = 1'b1;
    wait_ren("reset_release", 1);
    check_frame(8'h81, "reset_word", -1);
    check_idle("reset_word");
    check_pops("reset_word", 1);
  endtask

  task automatic test_single();
    fifo_q.push_back(8'hA5);
    wait_ren("single", 2);
    check_frame(8'hA5, "single_a5", -1);
    check_idle("single_a5");
    check_pops("single_a5", 2);
  endtask

  task automatic test_back_to_back();
    int bad;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h55);
    wait_ren("b2b", 2);
    check_frame(8'h00, "b2b_00", -1);
    @(negedge clk);
    check_frame(8'hFF, "b2b_ff", -1);
    @(negedge clk);
    check_frame(8'h55, "b2b_55", -1);
    check_idle("b2b_end");
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (txd !== 1'b1 || ren !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++;
      $display("FAIL b2b hold: got %0d bad cycles expected 0", bad);
    end
    check_pops("b2b", 5);
  endtask

  task automatic test_empty_hold();
    int bad;
    bad = 0;
    en = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1 || ren !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++;
      $display("FAIL empty_hold: got %0d bad cycles expected 0", bad);
    end
    check_pops("empty_hold", 5);
  endtask

  task automatic test_en_drop();
    int bad;
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'h5A);
    wait_ren("en_drop", 2);
    check_frame(8'hC3, "en_drop_c3", 4);
    check_idle("en_drop");
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ren !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++;
      $display("FAIL en_drop stall: got %0d bad cycles expected 0", bad);
    end
    check_pops("en_drop", 6);
    en = 1'b1;
    wait_ren("en_raise", 1);
    check_frame(8'h5A, "en_raise_5a", -1);
    check_idle("en_raise");
    check_pops("en_raise", 7);
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'h69);
    wait_ren("midrst", 2);
    repeat (19) @(negedge clk);
    n_cmp++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL midrst pre: txd=%b busy=%b expected 0 1", txd, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({txd, done, ren, busy} !== 4'b1000) begin
      n_mis++;
      $display("FAIL midrst async: txd/done/ren/busy got %b expected 1000", {txd, done, ren, busy});
    end
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if ({txd, done, ren, busy} !== 4'b1000) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++;
      $display("FAIL midrst hold: got %0d bad cycles expected 0", bad);
    end
    check_pops("midrst", 8);
    rst_n = 1'b1;
    wait_ren("midrst_release", 1);
    check_frame(8'h69, "midrst_69", -1);
    check_idle("midrst_69");
    check_pops("midrst_69", 9);
    n_cmp++;
    if (underflow != 0) begin
      n_mis++;
      $display("FAIL underflow: got %0d expected 0", underflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty_hold();
    test_en_drop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit drain for the team's synchronous FIFO (my_FIFO). The block sits directly downstream of the FIFO: it watches EMPTY, pops one word at a time through REN, and shifts each word out as an asynchronous 8N1-style frame on TXD. Frames are LSB first, with one start bit and one stop bit. It is the FIFO's only reader.

## Interface
Parameters:
- DATA_BIT, 8: word width. Must equal the FIFO DATA_BIT.
- CLKS_PER_BIT, 868: CLK cycles per serial bit (100 MHz / 115200). Legal range is ≥ 2.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- EN  in  1  transmit enable; gates only the start of a new fetch.
- EMPTY  in  1  FIFO EMPTY flag.
- DIN  in  DATA_BIT  FIFO DOUT; valid the cycle after REN is sampled high.
- REN  out  1  FIFO read enable; registered; exactly one cycle per word.
- TXD  out  1  serial line; idles high.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - If EN=1 and EMPTY=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: REN=1 for this single cycle, then go to LOAD.
- LOAD: shift register ← DIN, bit counter ← 0, then go to START.
- START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - TXD = shreg[0] for CLKS_PER_BIT cycles per bit.
  - Shift right after each bit.
  - After DATA_BIT bits, go to STOP.
- STOP:
  - TXD=1 for CLKS_PER_BIT cycles; DONE=1 on the final cycle.
  - On that final cycle, go to FETCH if EN=1 and EMPTY=0, otherwise go to IDLE.
- Width rules:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
  - Bit counter is $clog2(DATA_BIT)+1 bits.
  - No wrap-around beyond terminal counts.
- EMPTY is sampled only in IDLE and on the final STOP cycle. REN is never asserted while EMPTY=1.
- EN=0 during a frame: the frame completes unchanged and no further fetch occurs.
- EN=1 with EMPTY=1: stay in IDLE, BUSY=0.
- Reset (RST=0) at any time, including mid-frame:
  - Asynchronously forces state=IDLE, TXD=1, REN=0, BUSY=0, DONE=0, and clears counters and the shift register.
  - A partially sent word is lost. No FIFO word is popped during reset.

## Timing
- Reset values: TXD=1, REN=0, BUSY=0, DONE=0.
- Fetch latency:
  - EMPTY=0 sampled at edge k in IDLE: REN=1 during cycle k..k+1.
  - FIFO pops at edge k+1; DIN is captured at edge k+2.
  - TXD falls after edge k+2.
- Frame length (START through STOP) is (DATA_BIT+2)·CLKS_PER_BIT cycles.
- Back-to-back frames: TXD stays high for CLKS_PER_BIT+2 cycles between the last data bit and the next start bit (stop bit plus FETCH and LOAD).
- Throughput: one word per (DATA_BIT+2)·CLKS_PER_BIT+2 cycles.
- BUSY rises with FETCH. BUSY falls on the edge that enters IDLE, one cycle after DONE.
- The FIFO never sees REN on consecutive cycles, so no underflow or overlap is possible.

## Test plan
All scenarios use DATA_BIT=8 and CLKS_PER_BIT=4 (frame = 40 cycles).

1. Reset: hold RST=0 for 3 cycles with EMPTY=0 → TXD=1, REN=0, BUSY=0, DONE=0 throughout, and no FIFO pop.
2. Single word 0xA5:
   - EMPTY falls → exactly one REN pulse.
   - TXD, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
   - DONE pulses once, 40 cycles after TXD falls; then IDLE with BUSY=0.
3. Back-to-back 0x00, 0xFF, 0x55 queued:
   - Exactly 3 REN pulses, with a 6-cycle high gap between frames.
   - Third frame ends → IDLE, TXD held 1.
4. EMPTY=1 with EN=1 for 100 cycles → REN never asserts, BUSY=0, TXD=1.
5. EN dropped during the first data bit with 2 words queued → current frame completes, no second REN; EN raised again → second word sent with normal fetch latency.
6. RST=0 asserted mid-bit 3:
   - TXD=1 and BUSY=0 in the same time step, without waiting for an edge.
   - After release with EMPTY=0 → a fresh full 40-cycle frame of the next FIFO word, preceded by one REN.
